// File: rtl/rr_onehot_arb_pkg.sv
// ============================================================================
// Module : rr_onehot_arb_pkg
// Brief  : Shared definitions for the one-hot round-robin arbiter: scan
//          direction constants, FSM state type and a one-hot to binary encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rr_onehot_arb_pkg;

    localparam int c_DIR_RL = 0;
    localparam int c_DIR_LR = 1;

    // Encoder is sized for the widest supported arbiter; callers cast in/out.
    localparam int c_MAX_W    = 32;
    localparam int c_MAX_IDXW = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [c_MAX_IDXW-1:0] onehot_to_bin(input logic [c_MAX_W-1:0] oh);
        logic [c_MAX_IDXW-1:0] res;
        res = '0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if (oh[i]) begin
                res = res | c_MAX_IDXW'(i);
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_onehot_arb_pick.sv
// ============================================================================
// Module : prio_onehot_pick
// Brief  : Combinational round-robin pick. Returns the first request after
//          last_gnt in scan order, wrapping to the first request overall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prio_onehot_pick
    import rr_onehot_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LR_FIRST = 1
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] last_gnt,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH:0]   w_last_ext;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_first_masked;
    logic [WIDTH-1:0] w_first_all;

    assign w_last_ext = {1'b0, last_gnt};

    function automatic logic [WIDTH-1:0] first_one(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        res = '0;
        // Later hits overwrite earlier ones, so iterate toward the scan start.
        if (LR_FIRST == c_DIR_LR) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) res = WIDTH'(1) << i;
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) res = WIDTH'(1) << i;
            end
        end
        return res;
    endfunction

    generate
        if (LR_FIRST == c_DIR_LR) begin : g_mask_lr
            assign w_mask = WIDTH'(w_last_ext - (WIDTH+1)'(1));
        end else begin : g_mask_rl
            assign w_mask = ~WIDTH'((w_last_ext << 1) - (WIDTH+1)'(1));
        end
    endgenerate

    assign w_masked       = r & w_mask;
    assign w_first_masked = first_one(w_masked);
    assign w_first_all    = first_one(r);
    assign result         = (|w_masked) ? w_first_masked : w_first_all;

endmodule

`default_nettype wire

// File: rtl/rr_onehot_arb.sv
// ============================================================================
// Module : rr_onehot_arb
// Brief  : Round-robin arbiter with a registered one-hot grant held until the
//          grantee signals done; priority rotates past each completed grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_onehot_arb
    import rr_onehot_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LR_FIRST = 1,
    parameter int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_vld,
    output logic [IDXW-1:0]  gnt_idx
);

    // Pointer reset places the highest-priority end first in the next scan.
    localparam logic [WIDTH-1:0] c_LAST_RST = (LR_FIRST == c_DIR_LR) ?
                                              WIDTH'(1) : (WIDTH'(1) << (WIDTH - 1));

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_gnt;
    logic [WIDTH-1:0] w_gnt_nxt;
    logic [IDXW-1:0]  r_gnt_idx;
    logic [IDXW-1:0]  w_gnt_idx_nxt;
    logic [WIDTH-1:0] r_last_gnt;
    logic [WIDTH-1:0] w_last_nxt;
    logic [WIDTH-1:0] w_pick_r;
    logic [WIDTH-1:0] w_pick_last;
    logic [WIDTH-1:0] w_pick;

    prio_onehot_pick #(
        .WIDTH    (WIDTH),
        .LR_FIRST (LR_FIRST)
    ) u_pick (
        .r        (w_pick_r),
        .last_gnt (w_pick_last),
        .result   (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last_gnt;
        w_pick_r    = req;
        w_pick_last = r_last_gnt;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    // Handoff uses the outgoing grant as the pointer so the
                    // rotation takes effect in this same cycle.
                    w_pick_r    = req & ~r_gnt;
                    w_pick_last = r_gnt;
                    w_last_nxt  = r_gnt;
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = (|w_pick) ? ST_BUSY : ST_IDLE;
                end else if (~|(req & r_gnt)) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_gnt_idx_nxt = IDXW'(onehot_to_bin(c_MAX_W'(w_gnt_nxt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last_gnt <= c_LAST_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_last_gnt <= w_last_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = (r_state == ST_BUSY);
    assign gnt_idx = r_gnt_idx;

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arb.sv
// ============================================================================
// Module : tb_rr_onehot_arb
// Brief  : Directed self-checking bench for rr_onehot_arb in both scan
//          directions (WIDTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rr_onehot_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;

    logic [3:0] req_rl = '0;
    logic       done_rl = 1'b0;
    logic [3:0] gnt_rl;
    logic       vld_rl;
    logic [1:0] idx_rl;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_onehot_arb #(.WIDTH(4), .LR_FIRST(1)) dut_lr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    rr_onehot_arb #(.WIDTH(4), .LR_FIRST(0)) dut_rl (
        .clk     (clk),
        .rst     (rst),
        .req     (req_rl),
        .done    (done_rl),
        .gnt     (gnt_rl),
        .gnt_vld (vld_rl),
        .gnt_idx (idx_rl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0; done = 1'b0; req_rl = '0; done_rl = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_total++;
        if ({gnt, gnt_vld, gnt_idx} !== 7'b0) $display("FAIL reset_lr: got gnt=%b vld=%b idx=%0d, want 0/0/0", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        n_total++;
        if ({gnt_rl, vld_rl, idx_rl} !== 7'b0) $display("FAIL reset_rl: got gnt=%b vld=%b idx=%0d, want 0/0/0", gnt_rl, vld_rl, idx_rl);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_lr_rotation();
        logic [3:0] exp_g [3];
        logic [1:0] exp_i [3];
        exp_g = '{4'b1000, 4'b0010, 4'b0001};
        exp_i = '{2'd3, 2'd1, 2'd0};
        apply_reset();
        req = 4'b1011;
        step();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (gnt !== exp_g[k] || gnt_idx !== exp_i[k] || gnt_vld !== 1'b1)
                $display("FAIL lr_rot[%0d]: got gnt=%b idx=%0d vld=%b, want %b/%0d/1", k, gnt, gnt_idx, gnt_vld, exp_g[k], exp_i[k]);
            else n_pass++;
            done = 1'b1;
            if (k == 2) req = '0;
            step();
        end
        n_total++;
        if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0)
            $display("FAIL lr_idle: got gnt=%b vld=%b idx=%0d, want 0000/0/0", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        done = 1'b0;
    endtask

    task automatic test_rl_rotation();
        logic [3:0] exp_g [3];
        logic [1:0] exp_i [3];
        exp_g = '{4'b0001, 4'b0010, 4'b1000};
        exp_i = '{2'd0, 2'd1, 2'd3};
        apply_reset();
        req_rl = 4'b1011;
        step();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (gnt_rl !== exp_g[k] || idx_rl !== exp_i[k] || vld_rl !== 1'b1)
                $display("FAIL rl_rot[%0d]: got gnt=%b idx=%0d vld=%b, want %b/%0d/1", k, gnt_rl, idx_rl, vld_rl, exp_g[k], exp_i[k]);
            else n_pass++;
            done_rl = 1'b1;
            if (k == 2) req_rl = '0;
            step();
        end
        n_total++;
        if (gnt_rl !== 4'b0 || vld_rl !== 1'b0)
            $display("FAIL rl_idle: got gnt=%b vld=%b, want 0000/0", gnt_rl, vld_rl);
        else n_pass++;
        done_rl = 1'b0;
    endtask

    task automatic test_hold();
        apply_reset();
        req = 4'b0100;
        step();
        for (int k = 0; k < 5; k++) begin
            req = (k % 2 == 0) ? 4'b1111 : 4'b0100;
            step();
            n_total++;
            if (gnt !== 4'b0100 || gnt_vld !== 1'b1 || gnt_idx !== 2'd2)
                $display("FAIL hold[%0d]: got gnt=%b vld=%b idx=%0d, want 0100/1/2", k, gnt, gnt_vld, gnt_idx);
            else n_pass++;
        end
        req = '0;
        step();
    endtask

    task automatic test_withdraw();
        apply_reset();
        req = 4'b0100;
        step();
        req = 4'b0001;
        step();
        n_total++;
        if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0)
            $display("FAIL withdraw_idle: got gnt=%b vld=%b idx=%0d, want 0000/0/0", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        step();
        n_total++;
        if (gnt !== 4'b0001 || gnt_vld !== 1'b1 || gnt_idx !== 2'd0)
            $display("FAIL withdraw_regrant: got gnt=%b vld=%b idx=%0d, want 0001/1/0", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        // Done and withdrawal together: done wins and hands off.
        apply_reset();
        req = 4'b1011;
        step();
        req = 4'b0011; done = 1'b1;
        step();
        n_total++;
        if (gnt !== 4'b0010 || gnt_vld !== 1'b1 || gnt_idx !== 2'd1)
            $display("FAIL done_wins: got gnt=%b vld=%b idx=%0d, want 0010/1/1", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        req = '0;
        step();
        done = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [4];
        int         cnt [4];
        seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        cnt = '{0, 0, 0, 0};
        apply_reset();
        req = 4'b1111;
        step();
        done = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n_total++;
            if (gnt !== seq[k % 4] || gnt_vld !== 1'b1)
                $display("FAIL b2b[%0d]: got gnt=%b vld=%b, want %b/1", k, gnt, gnt_vld, seq[k % 4]);
            else n_pass++;
            for (int b = 0; b < 4; b++) if (gnt == seq[b]) cnt[b]++;
            step();
        end
        for (int b = 0; b < 4; b++) begin
            n_total++;
            if (cnt[b] !== 3) $display("FAIL b2b_count[%b]: got %0d grants, want 3", seq[b], cnt[b]);
            else n_pass++;
        end
        req = '0;
        step();
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0010;
        step();
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL areset_pre: got gnt=%b, want 0010", gnt);
        else n_pass++;
        req = 4'b1111;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0)
            $display("FAIL areset_clear: got gnt=%b vld=%b idx=%0d, want 0000/0/0", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step();
        n_total++;
        if (gnt !== 4'b1000 || gnt_vld !== 1'b1 || gnt_idx !== 2'd3)
            $display("FAIL areset_first: got gnt=%b vld=%b idx=%0d, want 1000/1/3", gnt, gnt_vld, gnt_idx);
        else n_pass++;
        req = '0; done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lr_rotation();
        test_rl_rotation();
        test_hold();
        test_withdraw();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
